// File: rtl/spi_response_arbiter_pkg.sv
// Shared types and constants for the SPI read-response arbiter.
package spi_response_arbiter_pkg;

  localparam int unsigned CountWidth          = 4;
  localparam logic [7:0]  DefaultStatusOpcode = 8'hDC;

  typedef enum logic [2:0] {
    StIdle,
    StArbitrate,
    StGranted,
    StNoResp,
    StStatus
  } arb_state_e;

  function automatic logic [CountWidth-1:0] sat_inc(input logic [CountWidth-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/spi_priority_encoder.sv
// Lowest-index-wins encoder with any/multiple flags for the response arbiter.
module spi_priority_encoder
  import spi_response_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQUESTERS = 4
) (
  input  logic [NUM_REQUESTERS-1:0]         valid_i,
  output logic [$clog2(NUM_REQUESTERS)-1:0] index_o,
  output logic                              any_valid_o,
  output logic                              multiple_valid_o
);

  localparam int unsigned IdxW = $clog2(NUM_REQUESTERS);

  always_comb begin
    index_o = '0;
    // Walk downwards so the lowest set bit is the last one written.
    for (int i = int'(NUM_REQUESTERS) - 1; i >= 0; i--) begin
      if (valid_i[i]) begin
        index_o = IdxW'(i);
      end
    end
    any_valid_o      = |valid_i;
    // Clearing the lowest set bit leaves something only if two or more were set.
    multiple_valid_o = |(valid_i & (valid_i - NUM_REQUESTERS'(1)));
  end

endmodule

// File: rtl/spi_response_arbiter.sv
// Grants one responder per SPI transaction, forwards its byte and answers a status opcode.
module spi_response_arbiter
  import spi_response_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQUESTERS = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [7:0]  STATUS_OPCODE  = DefaultStatusOpcode
) (
  input  logic                        clock_in,
  input  logic                        reset_n_in,
  input  logic [7:0]                  opcode_in,
  input  logic                        opcode_valid_in,
  input  logic [8*NUM_REQUESTERS-1:0] response_in,
  input  logic [NUM_REQUESTERS-1:0]   response_valid_in,
  output logic [7:0]                  response_out,
  output logic                        response_valid_out,
  output logic                        conflict_out
);

  localparam int unsigned IdxW       = $clog2(NUM_REQUESTERS);
  localparam logic [7:0]  TimeoutVal = 8'(TIMEOUT_CYCLES);

  arb_state_e            state_q;
  logic [IdxW-1:0]       grant_q;
  logic [7:0]            timer_q;
  logic [CountWidth-1:0] conflict_cnt_q;
  logic [CountWidth-1:0] miss_cnt_q;
  logic                  opcode_valid_prev_q;

  logic [IdxW-1:0] enc_index;
  logic            enc_any;
  logic            enc_multiple;
  logic            start;
  logic [7:0]      resp_bytes [NUM_REQUESTERS];

  always_comb begin
    for (int i = 0; i < int'(NUM_REQUESTERS); i++) begin
      resp_bytes[i] = response_in[8*i +: 8];
    end
  end

  assign start = opcode_valid_in & ~opcode_valid_prev_q;

  spi_priority_encoder #(
    .NUM_REQUESTERS(NUM_REQUESTERS)
  ) u_encoder (
    .valid_i         (response_valid_in),
    .index_o         (enc_index),
    .any_valid_o     (enc_any),
    .multiple_valid_o(enc_multiple)
  );

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q             <= StIdle;
      grant_q             <= '0;
      timer_q             <= '0;
      conflict_cnt_q      <= '0;
      miss_cnt_q          <= '0;
      response_out        <= '0;
      response_valid_out  <= 1'b0;
      conflict_out        <= 1'b0;
      // Treat the line as already high so a transaction in flight across reset is not a start.
      opcode_valid_prev_q <= 1'b1;
    end else begin
      opcode_valid_prev_q <= opcode_valid_in;
      if (state_q != StIdle && !opcode_valid_in) begin
        state_q            <= StIdle;
        response_out       <= '0;
        response_valid_out <= 1'b0;
        if (state_q == StStatus) begin
          conflict_cnt_q <= '0;
          miss_cnt_q     <= '0;
          conflict_out   <= 1'b0;
        end
      end else begin
        case (state_q)
          StIdle: begin
            response_out       <= '0;
            response_valid_out <= 1'b0;
            if (start) begin
              if (opcode_in == STATUS_OPCODE) begin
                state_q            <= StStatus;
                response_out       <= {miss_cnt_q, conflict_cnt_q};
                response_valid_out <= 1'b1;
              end else begin
                state_q <= StArbitrate;
                timer_q <= '0;
              end
            end
          end
          StArbitrate: begin
            if (enc_any) begin
              state_q            <= StGranted;
              grant_q            <= enc_index;
              response_out       <= resp_bytes[enc_index];
              response_valid_out <= 1'b1;
              if (enc_multiple) begin
                conflict_cnt_q <= sat_inc(conflict_cnt_q);
                conflict_out   <= 1'b1;
              end
            end else begin
              timer_q <= timer_q + 8'd1;
              if (timer_q + 8'd1 == TimeoutVal) begin
                miss_cnt_q <= sat_inc(miss_cnt_q);
                state_q    <= StNoResp;
              end
            end
          end
          StGranted: begin
            response_out       <= resp_bytes[grant_q];
            response_valid_out <= response_valid_in[grant_q];
          end
          StNoResp: begin
            response_out       <= '0;
            response_valid_out <= 1'b0;
          end
          StStatus: begin
            // Snapshot taken on entry is held for the whole transaction.
          end
          default: begin
            state_q            <= StIdle;
            response_out       <= '0;
            response_valid_out <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_response_arbiter.sv
// Self-checking bench: directed vector table, corner-case sequences and a random run vs a model.
module tb_spi_response_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  op = '0;
  logic        ov = 1'b0;
  logic [31:0] rsp = '0;
  logic [3:0]  rv = '0;
  logic [7:0]  resp_o;
  logic        v_o;
  logic        c_o;

  always #5 clk = ~clk;

  spi_response_arbiter #(
    .NUM_REQUESTERS(N),
    .TIMEOUT_CYCLES(TO),
    .STATUS_OPCODE (8'hDC)
  ) dut (
    .clock_in          (clk),
    .reset_n_in        (rst_n),
    .opcode_in         (op),
    .opcode_valid_in   (ov),
    .response_in       (rsp),
    .response_valid_in (rv),
    .response_out      (resp_o),
    .response_valid_out(v_o),
    .conflict_out      (c_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: phase 0 none, 1 waiting, 2 owned, 3 missed, 4 status.
  int         m_phase, m_wait, m_owner, m_conf, m_miss;
  bit         m_flag, m_prev;
  logic [7:0] m_resp;
  bit         m_v;

  task automatic model_reset();
    m_phase = 0; m_wait = 0; m_owner = 0; m_conf = 0; m_miss = 0;
    m_flag = 0; m_prev = 1; m_resp = 0; m_v = 0;
  endtask

  function automatic int lowest(input logic [3:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_step();
    bit is_start = ov && !m_prev;
    m_prev = ov;
    if (m_phase != 0 && !ov) begin
      if (m_phase == 4) begin m_conf = 0; m_miss = 0; m_flag = 0; end
      m_phase = 0; m_resp = 0; m_v = 0;
    end else if (m_phase == 0) begin
      m_resp = 0; m_v = 0;
      if (is_start && op == 8'hDC) begin
        m_phase = 4; m_resp = 8'(m_miss * 16 + m_conf); m_v = 1;
      end else if (is_start) begin
        m_phase = 1; m_wait = 0;
      end
    end else if (m_phase == 1) begin
      if ($countones(rv) > 0) begin
        m_owner = lowest(rv);
        if ($countones(rv) > 1) begin
          m_conf = (m_conf < 15) ? m_conf + 1 : 15;
          m_flag = 1;
        end
        m_phase = 2; m_resp = rsp[8*m_owner +: 8]; m_v = 1;
      end else begin
        m_wait++;
        if (m_wait == TO) begin
          m_miss = (m_miss < 15) ? m_miss + 1 : 15;
          m_phase = 3;
        end
      end
    end else if (m_phase == 2) begin
      m_resp = rsp[8*m_owner +: 8]; m_v = rv[m_owner];
    end else if (m_phase == 3) begin
      m_resp = 0; m_v = 0;
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] o, input logic [3:0] r,
                       input logic [31:0] d);
    ov = v; op = o; rv = r; rsp = d;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    model_step();
    check({tag, " resp"}, resp_o, m_resp);
    check({tag, " valid"}, {7'b0, v_o}, {7'b0, m_v});
    check({tag, " conflict"}, {7'b0, c_o}, {7'b0, m_flag});
  endtask

  task automatic status_read(output logic [7:0] value);
    drive(1, 8'hDC, 0, 0);
    step("status start");
    value = resp_o;
    step("status hold");
    check("status held", resp_o, value);
    drive(0, 0, 0, 0);
    step("status end");
  endtask

  task automatic conflict_txn();
    drive(1, 8'h10, 4'b0011, $urandom);
    step("sat start");
    step("sat grant");
    drive(0, 0, 0, 0);
    step("sat end");
  endtask

  typedef struct {
    logic        ov;
    logic [7:0]  op;
    logic [3:0]  rv;
    logic [31:0] rsp;
    logic        ev;
    logic [7:0]  er;
  } vec_t;

  vec_t       tbl [9];
  logic [7:0] sv;

  initial begin
    tbl[0] = '{1'b0, 8'h00, 4'b0000, 32'h0,          1'b0, 8'h00};
    tbl[1] = '{1'b1, 8'hDB, 4'b0000, 32'h0,          1'b0, 8'h00};
    tbl[2] = '{1'b1, 8'hDB, 4'b0000, 32'h0,          1'b0, 8'h00};
    tbl[3] = '{1'b1, 8'hDB, 4'b0000, 32'h0,          1'b0, 8'h00};
    tbl[4] = '{1'b1, 8'hDB, 4'b0010, 32'h0000_8100,  1'b1, 8'h81};
    tbl[5] = '{1'b1, 8'h33, 4'b0010, 32'h0000_8100,  1'b1, 8'h81};
    tbl[6] = '{1'b1, 8'hDB, 4'b0010, 32'h0000_8100,  1'b1, 8'h81};
    tbl[7] = '{1'b0, 8'hDB, 4'b0010, 32'h0000_8100,  1'b0, 8'h00};
    tbl[8] = '{1'b0, 8'h00, 4'b0000, 32'h0,          1'b0, 8'h00};

    model_reset();
    #12 rst_n = 1'b1;
    check("reset resp", resp_o, 8'h00);
    check("reset valid", {7'b0, v_o}, 8'h00);
    check("reset conflict", {7'b0, c_o}, 8'h00);

    // Single responder, table driven.
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].ov, tbl[i].op, tbl[i].rv, tbl[i].rsp);
      step("tbl");
      check($sformatf("tbl[%0d] resp", i), resp_o, tbl[i].er);
      check($sformatf("tbl[%0d] valid", i), {7'b0, v_o}, {7'b0, tbl[i].ev});
    end

    // Conflict, then status read clears the sticky flag.
    drive(1, 8'h20, 0, 0);
    step("conf start");
    drive(1, 8'h20, 4'b0101, 32'h0022_0011);
    step("conf grant");
    check("conf resp", resp_o, 8'h11);
    check("conf flag", {7'b0, c_o}, 8'h01);
    drive(0, 0, 0, 0);
    step("conf end");
    status_read(sv);
    check("conf status", sv, 8'h01);
    check("conf flag cleared", {7'b0, c_o}, 8'h00);

    // Miss.
    drive(1, 8'hDB, 0, 0);
    repeat (TO + 4) step("miss");
    check("miss valid", {7'b0, v_o}, 8'h00);
    drive(0, 0, 0, 0);
    step("miss end");
    status_read(sv);
    check("miss status", sv, 8'h10);

    // Saturation.
    repeat (20) conflict_txn();
    status_read(sv);
    check("sat status", sv, 8'h0F);
    status_read(sv);
    check("sat cleared", sv, 8'h00);

    // End wins over a simultaneous grant.
    drive(1, 8'hDB, 0, 0);
    step("endp start");
    drive(0, 8'hDB, 4'b1000, 32'h4400_0000);
    step("endp fall");
    check("endp valid", {7'b0, v_o}, 8'h00);
    drive(0, 0, 0, 0);
    step("endp idle");
    status_read(sv);
    check("endp status", sv, 8'h00);

    // No re-arbitration after the owner drops.
    drive(1, 8'hDB, 0, 0);
    step("rearb start");
    drive(1, 8'hDB, 4'b0001, 32'h0000_5AA5);
    step("rearb grant");
    check("rearb resp", resp_o, 8'hA5);
    drive(1, 8'hDB, 4'b0010, 32'h0000_5AA5);
    step("rearb drop");
    check("rearb drop valid", {7'b0, v_o}, 8'h00);
    step("rearb hold");
    check("rearb not regranted", {7'b0, v_o}, 8'h00);
    drive(0, 0, 0, 0);
    step("rearb end");

    // Reset mid-transaction with conflict flag set.
    drive(1, 8'h20, 0, 0);
    step("rst start");
    drive(1, 8'h20, 4'b0011, 32'h0000_6655);
    step("rst grant");
    check("rst pre flag", {7'b0, c_o}, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    check("rst async resp", resp_o, 8'h00);
    check("rst async valid", {7'b0, v_o}, 8'h00);
    check("rst async flag", {7'b0, c_o}, 8'h00);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step("rst held high");
    check("rst no start", {7'b0, v_o}, 8'h00);
    drive(0, 0, 0, 0);
    step("rst fall");
    drive(1, 8'hDB, 4'b0100, 32'h0077_0000);
    step("rst restart");
    step("rst regrant");
    check("rst regrant resp", resp_o, 8'h77);
    drive(0, 0, 0, 0);
    step("rst end");
    status_read(sv);
    check("rst status", sv, 8'h00);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if (ov) ov = ($urandom_range(0, 7) != 0);
      else    ov = ($urandom_range(0, 2) == 0);
      op  = ($urandom_range(0, 3) == 0) ? 8'hDC : 8'($urandom);
      rv  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      rsp = $urandom;
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_response_arbiter.md
Name: spi_response_arbiter

Overview:
- Shares the single SPI read-response path of spi_peripheral between up to NUM_REQUESTERS subsystems (camera, chip-ID and other registers, future blocks).
- Per SPI transaction, grants exactly one requester, holds that grant until the transaction ends, and forwards its byte.
- Counts conflicts (multiple responders) and misses (no responder), exposing both through a built-in status opcode.
- Sits in the spi_peripheral_clock domain between the responding blocks and the spi_peripheral response inputs.

Parameters:
- NUM_REQUESTERS, 4: number of response sources, 2..8.
- TIMEOUT_CYCLES, 16: cycles after transaction start to wait for any response_valid before declaring a miss, 1..255.
- STATUS_OPCODE, 8'hDC: opcode answered by this block itself.

Ports:
- clock_in  input  1  spi_peripheral_clock.
- reset_n_in  input  1  asynchronous active-low reset.
- opcode_in  input  8  current SPI opcode.
- opcode_valid_in  input  1  high for the duration of an SPI transaction.
- response_in  input  8*NUM_REQUESTERS  packed bytes; requester i in bits [8i+7:8i].
- response_valid_in  input  NUM_REQUESTERS  per-requester valid.
- response_out  output  8  byte to spi_peripheral.
- response_valid_out  output  1  response_out is valid.
- conflict_out  output  1  sticky flag: a conflict has occurred since the last status read.

Behaviour:
- Reset (asynchronous, any state): state IDLE; response_out=0, response_valid_out=0, conflict_out=0; conflict_count=0, miss_count=0, grant index=0, timer=0.
- All outputs are registered. Start is the rising edge of opcode_valid_in (registered previous value 0, current 1).
- IDLE:
  - Outputs invalid.
  - On start with opcode_in==STATUS_OPCODE -> STATUS.
  - On any other start -> ARBITRATE with timer cleared.
- ARBITRATE:
  - Each cycle, if any response_valid_in bit is set: grant the lowest-index set bit and go to GRANTED.
  - If more than one bit is set in that same cycle: conflict_count += 1 (4-bit, saturates at 15) and conflict_out <= 1.
  - If no bit is set: timer += 1. When timer reaches TIMEOUT_CYCLES: miss_count += 1 (4-bit, saturates at 15) and go to NO_RESP.
- GRANTED:
  - Each cycle, response_out <= response_in[grant] and response_valid_out <= response_valid_in[grant]. Latency from input to output is 1 cycle.
  - The grant is not re-arbitrated. Valids from other requesters are ignored and are not counted as conflicts.
  - If the granted requester drops valid, response_valid_out follows one cycle later.
- NO_RESP: response_out=0, response_valid_out=0 until the transaction ends.
- STATUS:
  - response_out <= {miss_count, conflict_count} and response_valid_out <= 1, held for the whole transaction. The value is snapshotted on entry.
  - On exit, both counters and conflict_out are cleared. Events that occur while in STATUS cannot happen, because only one transaction is active at a time.
- Transaction end: opcode_valid_in low in any non-IDLE state.
  - Next cycle: state IDLE, response_valid_out=0, response_out=0.
  - The end condition takes priority over a simultaneous grant or timeout in the same cycle. Neither counter is incremented in that case.
- Opcode changes while opcode_valid_in stays high are ignored; no new start occurs.
- A requester that raises valid while the block is in IDLE is ignored, and nothing is counted.
- Counters saturate and never wrap.

Decomposition:
- Package spi_response_arbiter_pkg holds:
  - the state enum {IDLE, ARBITRATE, GRANTED, NO_RESP, STATUS};
  - the default STATUS_OPCODE constant;
  - the counter width constant (4).
- Sub-module spi_priority_encoder, purely combinational:
  - Input: NUM_REQUESTERS-bit vector.
  - Outputs: lowest set index ($clog2 width), any_valid, multiple_valid.

Test Plan:
- Single responder:
  - Stimulus: start opcode 8'hDB; requester 1 asserts valid with 8'h81 three cycles later.
  - Required: response_out=8'h81 and response_valid_out=1 exactly one cycle after, held until opcode_valid_in falls; invalid one cycle after the fall.
- Conflict:
  - Stimulus: requesters 0 (8'h11) and 2 (8'h22) assert valid in the same cycle.
  - Required: response_out=8'h11, conflict_out=1.
  - Then a start with 8'hDC returns 8'h01, and after that transaction conflict_out=0.
- Miss:
  - Stimulus: start with no responder; TIMEOUT_CYCLES=16.
  - Required: response_valid_out stays 0; a subsequent status read returns 8'h10.
- Saturation:
  - Stimulus: 20 consecutive conflict transactions.
  - Required: status read returns 8'h0F; a second status read returns 8'h00.
- End priority and no re-arbitration:
  - Stimulus: opcode_valid_in falls in the same cycle requester 3 asserts valid.
  - Required: no grant and no count; state IDLE.
  - Stimulus: granted requester 0 drops valid while requester 1 asserts.
  - Required: response_valid_out goes 0; requester 1 is not granted.
- Reset mid-transaction:
  - Stimulus: assert reset_n_in=0 during GRANTED.
  - Required: outputs go 0 immediately, without waiting for a clock edge; counters and conflict_out clear.
  - Stimulus: after release, opcode_valid_in is still high.
  - Required: no start until opcode_valid_in falls and then rises again.
